// File: rtl/axis_frame_length_limit.sv
// AXI4-Stream frame length limiter: registered skid buffer with per-frame beat counting,
// truncation of over-long frames and per-frame length/truncation status.
module axis_frame_length_limit #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 1518,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  frame_len_valid,
    output logic                  frame_truncated
);

    typedef enum logic {PASS, DROP} state_t;

    localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(MAX_LEN - 1);

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]    frame_len_q, frame_len_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    out_user_q, out_user_d;
    logic                    temp_valid_q, temp_valid_d;
    logic [DATA_WIDTH-1:0]   temp_data_q, temp_data_d;
    logic                    temp_last_q, temp_last_d;
    logic                    temp_user_q, temp_user_d;

    logic drop_mode;
    logic accept;
    logic at_limit;
    logic wr_en;
    logic trunc;
    logic status_valid;
    logic wr_last;
    logic wr_user;

    // While dropping, the tail of the frame is sunk regardless of downstream backpressure.
    assign drop_mode         = (state_q == DROP);
    assign input_axis_tready = in_ready_q | drop_mode;
    assign accept            = input_axis_tvalid & input_axis_tready;
    assign at_limit          = (beat_cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            PASS: begin
                if (accept) begin
                    if (input_axis_tlast) begin
                        beat_cnt_d = '0;
                    end else if (at_limit) begin
                        beat_cnt_d = '0;
                        state_d    = DROP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            DROP: begin
                if (accept && input_axis_tlast) begin
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_comb begin
        wr_en        = 1'b0;
        trunc        = 1'b0;
        status_valid = 1'b0;
        if (state_q == PASS) begin
            wr_en        = accept;
            trunc        = accept & ~input_axis_tlast & at_limit;
            status_valid = accept & (input_axis_tlast | at_limit);
        end
    end

    assign wr_last         = input_axis_tlast | trunc;
    assign wr_user         = input_axis_tuser | trunc;
    assign frame_len_d     = status_valid ? (beat_cnt_q + LEN_WIDTH'(1)) : frame_len_q;
    assign frame_len       = frame_len_d;
    assign frame_len_valid = status_valid;
    assign frame_truncated = trunc;

    // Ready is registered, so at most one beat can land after a stall; it parks in temp.
    always_comb begin
        in_ready_d   = output_axis_tready | (~temp_valid_q & (~out_valid_q | ~input_axis_tvalid));
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_user_d   = out_user_q;
        temp_valid_d = temp_valid_q;
        temp_data_d  = temp_data_q;
        temp_last_d  = temp_last_q;
        temp_user_d  = temp_user_q;
        if (in_ready_q) begin
            if (output_axis_tready || !out_valid_q) begin
                out_valid_d = wr_en;
                if (wr_en) begin
                    out_data_d = input_axis_tdata;
                    out_last_d = wr_last;
                    out_user_d = wr_user;
                end
            end else begin
                temp_valid_d = wr_en;
                if (wr_en) begin
                    temp_data_d = input_axis_tdata;
                    temp_last_d = wr_last;
                    temp_user_d = wr_user;
                end
            end
        end else if (output_axis_tready) begin
            out_valid_d  = temp_valid_q;
            out_data_d   = temp_data_q;
            out_last_d   = temp_last_q;
            out_user_d   = temp_user_q;
            temp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q   <= '0;
            frame_len_q  <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= 1'b0;
            temp_valid_q <= 1'b0;
            temp_data_q  <= '0;
            temp_last_q  <= 1'b0;
            temp_user_q  <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            frame_len_q  <= frame_len_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_user_q   <= out_user_d;
            temp_valid_q <= temp_valid_d;
            temp_data_q  <= temp_data_d;
            temp_last_q  <= temp_last_d;
            temp_user_q  <= temp_user_d;
        end
    end

    assign output_axis_tvalid = out_valid_q;
    assign output_axis_tdata  = out_data_q;
    assign output_axis_tlast  = out_last_q;
    assign output_axis_tuser  = out_user_q;

endmodule

// File: tb/tb_axis_frame_length_limit.sv
// Directed bench for axis_frame_length_limit: one instance with MAX_LEN=4, one with MAX_LEN=1,
// sharing clock, reset and downstream ready; sel picks which one is driven and observed.
module tb_axis_frame_length_limit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_user = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;

    logic        valid4, ready4, ovalid4, olast4, ouser4, fv4, ft4;
    logic [7:0]  odata4;
    logic [15:0] flen4;
    logic        valid1, ready1, ovalid1, olast1, ouser1, fv1, ft1;
    logic [7:0]  odata1;
    logic [15:0] flen1;

    logic        cur_ready, cur_valid, cur_last, cur_user, cur_fv, cur_ft;
    logic [7:0]  cur_data;
    logic [15:0] cur_flen;

    int          test_count = 0;
    int          fail_count = 0;

    logic [7:0]  got_data[$];
    logic        got_last[$];
    logic        got_user[$];
    logic [15:0] got_len[$];
    logic        got_trunc[$];
    logic [7:0]  exp_data[$];
    logic        exp_last[$];
    logic        exp_user[$];
    logic [15:0] exp_len[$];
    logic        exp_trunc[$];
    int          beat_ptr = 0;
    int          pulse_ptr = 0;
    int          stall_violations = 0;

    logic        toggle_mode = 1'b0;
    int          phase = 0;
    logic [3:0]  pattern = 4'b1001;

    always #5 clk = ~clk;

    assign valid4 = in_valid & ~sel;
    assign valid1 = in_valid & sel;

    axis_frame_length_limit #(.DATA_WIDTH(8), .MAX_LEN(4), .LEN_WIDTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .input_axis_tdata(in_data), .input_axis_tvalid(valid4), .input_axis_tready(ready4),
        .input_axis_tlast(in_last), .input_axis_tuser(in_user),
        .output_axis_tdata(odata4), .output_axis_tvalid(ovalid4), .output_axis_tready(out_ready),
        .output_axis_tlast(olast4), .output_axis_tuser(ouser4),
        .frame_len(flen4), .frame_len_valid(fv4), .frame_truncated(ft4)
    );

    axis_frame_length_limit #(.DATA_WIDTH(8), .MAX_LEN(1), .LEN_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .input_axis_tdata(in_data), .input_axis_tvalid(valid1), .input_axis_tready(ready1),
        .input_axis_tlast(in_last), .input_axis_tuser(in_user),
        .output_axis_tdata(odata1), .output_axis_tvalid(ovalid1), .output_axis_tready(out_ready),
        .output_axis_tlast(olast1), .output_axis_tuser(ouser1),
        .frame_len(flen1), .frame_len_valid(fv1), .frame_truncated(ft1)
    );

    assign cur_ready = sel ? ready1 : ready4;
    assign cur_valid = sel ? ovalid1 : ovalid4;
    assign cur_data  = sel ? odata1 : odata4;
    assign cur_last  = sel ? olast1 : olast4;
    assign cur_user  = sel ? ouser1 : ouser4;
    assign cur_fv    = sel ? fv1 : fv4;
    assign cur_ft    = sel ? ft1 : ft4;
    assign cur_flen  = sel ? flen1 : flen4;

    // Negedge monitor: collects delivered beats and status pulses, and watches stall stability.
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    logic        prev_user = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!cur_valid || cur_data !== prev_data ||
                               cur_last !== prev_last || cur_user !== prev_user))
                stall_violations++;
            prev_stall = cur_valid & ~out_ready;
            prev_data  = cur_data;
            prev_last  = cur_last;
            prev_user  = cur_user;
            if (cur_valid && out_ready) begin
                got_data.push_back(cur_data);
                got_last.push_back(cur_last);
                got_user.push_back(cur_user);
            end
            if (cur_fv) begin
                got_len.push_back(cur_flen);
                got_trunc.push_back(cur_ft);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) begin
            phase     = (phase + 1) % 4;
            out_ready = pattern[phase];
        end
    endtask

    // Presents one beat and holds it until accepted; returns the status seen in the accept cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input logic user,
                                 output logic fv, output logic [15:0] fl, output logic ft);
        logic acc;
        acc = 1'b0;
        fv  = 1'b0;
        fl  = '0;
        ft  = 1'b0;
        in_data  = d;
        in_last  = last;
        in_user  = user;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = cur_ready;
            fv  = cur_fv;
            fl  = cur_flen;
            ft  = cur_ft;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic expectBeat(input logic [7:0] d, input logic last, input logic user);
        exp_data.push_back(d);
        exp_last.push_back(last);
        exp_user.push_back(user);
    endtask

    task automatic expectPulse(input logic [15:0] len, input logic tr);
        exp_len.push_back(len);
        exp_trunc.push_back(tr);
    endtask

    task automatic checkStreams(input string tag);
        checkOutput({tag, "_beat_count"}, got_data.size(), exp_data.size());
        for (int i = beat_ptr; i < exp_data.size() && i < got_data.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, got_data[i]}, {24'd0, exp_data[i]});
            checkOutput($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]}, {31'd0, exp_last[i]});
            checkOutput($sformatf("%s_user%0d", tag, i), {31'd0, got_user[i]}, {31'd0, exp_user[i]});
        end
        beat_ptr = exp_data.size();
        checkOutput({tag, "_pulse_count"}, got_len.size(), exp_len.size());
        for (int i = pulse_ptr; i < exp_len.size() && i < got_len.size(); i++) begin
            checkOutput($sformatf("%s_len%0d", tag, i), {16'd0, got_len[i]}, {16'd0, exp_len[i]});
            checkOutput($sformatf("%s_trunc%0d", tag, i), {31'd0, got_trunc[i]}, {31'd0, exp_trunc[i]});
        end
        pulse_ptr = exp_len.size();
    endtask

    initial begin
        logic        fv, ft;
        logic [15:0] fl;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, ready4}, 32'd0);
        checkOutput("rst_valid", {31'd0, ovalid4}, 32'd0);
        checkOutput("rst_data", {24'd0, odata4}, 32'd0);
        checkOutput("rst_flen", {16'd0, flen4}, 32'd0);
        checkOutput("rst_fv", {31'd0, fv4}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_edge", {31'd0, ready4}, 32'd0);
        tick();
        checkOutput("ready_after_rst", {31'd0, ready4}, 32'd1);

        // 3-beat frame, one-cycle latency, status in the accept cycle
        applyStimulus(8'h11, 1'b0, 1'b0, fv, fl, ft);
        checkOutput("t1_lat_valid", {31'd0, cur_valid}, 32'd1);
        checkOutput("t1_lat_data", {24'd0, cur_data}, 32'h11);
        checkOutput("t1_fv_mid", {31'd0, fv}, 32'd0);
        applyStimulus(8'h22, 1'b0, 1'b0, fv, fl, ft);
        checkOutput("t1_lat_data2", {24'd0, cur_data}, 32'h22);
        applyStimulus(8'h33, 1'b1, 1'b0, fv, fl, ft);
        checkOutput("t1_lat_data3", {24'd0, cur_data}, 32'h33);
        checkOutput("t1_lat_last3", {31'd0, cur_last}, 32'd1);
        checkOutput("t1_fv", {31'd0, fv}, 32'd1);
        checkOutput("t1_flen", {16'd0, fl}, 32'd3);
        checkOutput("t1_ft", {31'd0, ft}, 32'd0);
        expectBeat(8'h11, 0, 0); expectBeat(8'h22, 0, 0); expectBeat(8'h33, 1, 0);
        expectPulse(16'd3, 0);
        repeat (3) tick();
        checkOutput("t1_flen_hold", {16'd0, cur_flen}, 32'd3);
        checkOutput("t1_idle_valid", {31'd0, cur_valid}, 32'd0);
        checkStreams("t1");

        // 6-beat frame truncated at 4, then a 1-beat frame
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'hA0 + 8'(i), (i == 5), 1'b0, fv, fl, ft);
            if (i == 3) begin
                checkOutput("t2_fv", {31'd0, fv}, 32'd1);
                checkOutput("t2_flen", {16'd0, fl}, 32'd4);
                checkOutput("t2_ft", {31'd0, ft}, 32'd1);
            end else if (i > 3) begin
                checkOutput($sformatf("t2_drop_fv%0d", i), {31'd0, fv}, 32'd0);
            end
        end
        applyStimulus(8'hB0, 1'b1, 1'b0, fv, fl, ft);
        checkOutput("t2b_flen", {16'd0, fl}, 32'd1);
        checkOutput("t2b_ft", {31'd0, ft}, 32'd0);
        expectBeat(8'hA0, 0, 0); expectBeat(8'hA1, 0, 0); expectBeat(8'hA2, 0, 0);
        expectBeat(8'hA3, 1, 1); expectBeat(8'hB0, 1, 0);
        expectPulse(16'd4, 1); expectPulse(16'd1, 0);
        repeat (3) tick();
        checkStreams("t2");

        // Exactly MAX_LEN beats with tuser on the last beat
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hC0 + 8'(i), (i == 3), (i == 3), fv, fl, ft);
        end
        checkOutput("t3_flen", {16'd0, fl}, 32'd4);
        checkOutput("t3_ft", {31'd0, ft}, 32'd0);
        expectBeat(8'hC0, 0, 0); expectBeat(8'hC1, 0, 0); expectBeat(8'hC2, 0, 0);
        expectBeat(8'hC3, 1, 1);
        expectPulse(16'd4, 0);
        repeat (3) tick();
        checkStreams("t3");

        // 16 beats in 2-beat frames under a 1,0,0,1 downstream ready pattern
        phase       = 0;
        out_ready   = pattern[0];
        toggle_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'h40 + 8'(i), (i % 2 == 1), 1'b0, fv, fl, ft);
            expectBeat(8'h40 + 8'(i), (i % 2 == 1), 1'b0);
            if (i % 2 == 1) expectPulse(16'd2, 0);
        end
        repeat (12) tick();
        toggle_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (3) tick();
        checkStreams("t4");
        checkOutput("t4_stall_stable", stall_violations, 32'd0);

        // Reset in the middle of a frame
        applyStimulus(8'h50, 1'b0, 1'b0, fv, fl, ft);
        applyStimulus(8'h51, 1'b0, 1'b0, fv, fl, ft);
        checkOutput("t5_pre_valid", {31'd0, cur_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", {31'd0, ovalid4}, 32'd0);
        checkOutput("t5_rst_data", {24'd0, odata4}, 32'd0);
        checkOutput("t5_rst_ready", {31'd0, ready4}, 32'd0);
        checkOutput("t5_rst_flen", {16'd0, flen4}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_ready_low", {31'd0, ready4}, 32'd0);
        tick();
        checkOutput("t5_ready_high", {31'd0, ready4}, 32'd1);
        applyStimulus(8'hD0, 1'b0, 1'b0, fv, fl, ft);
        applyStimulus(8'hD1, 1'b1, 1'b0, fv, fl, ft);
        checkOutput("t5_flen", {16'd0, fl}, 32'd2);
        checkOutput("t5_ft", {31'd0, ft}, 32'd0);
        expectBeat(8'h50, 0, 0); expectBeat(8'hD0, 0, 0); expectBeat(8'hD1, 1, 0);
        expectPulse(16'd2, 0);
        repeat (3) tick();
        checkStreams("t5");

        // MAX_LEN=1 instance
        sel = 1'b1;
        tick();
        applyStimulus(8'hE0, 1'b0, 1'b0, fv, fl, ft);
        checkOutput("t6_flen", {16'd0, fl}, 32'd1);
        checkOutput("t6_ft", {31'd0, ft}, 32'd1);
        applyStimulus(8'hE1, 1'b1, 1'b0, fv, fl, ft);
        checkOutput("t6_drop_fv", {31'd0, fv}, 32'd0);
        applyStimulus(8'hF0, 1'b1, 1'b0, fv, fl, ft);
        checkOutput("t6b_flen", {16'd0, fl}, 32'd1);
        checkOutput("t6b_ft", {31'd0, ft}, 32'd0);
        expectBeat(8'hE0, 1, 1); expectBeat(8'hF0, 1, 0);
        expectPulse(16'd1, 1); expectPulse(16'd1, 0);
        repeat (3) tick();
        checkStreams("t6");

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
